// File: rtl/flag_cond_eval.sv
// Branch condition evaluator: latches a decoder request, waits out a same-cycle
// flag update, evaluates the condition and returns taken/pc_load. Optional counters: BRANCH_STATS_EN.
module flag_cond_eval #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        status_flags,
    input  logic              flags_ld,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [ADDR_W-1:0] req_target,
    output logic              res_valid,
    input  logic              res_ack,
    output logic              res_taken,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target
`ifdef BRANCH_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  eval_cnt,
    output logic [CNT_W-1:0]  taken_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2,
        RESP       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cond_q, cond_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              valid_q, valid_d;
    logic              taken_q, taken_d;
    logic              pcld_q, pcld_d;
    logic              cond_true;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Flag order: [0]=C [1]=Z [2]=S [3]=V [4]=P
    function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
        logic cf, zf, sf, vf, pf;
        cf = f[0];
        zf = f[1];
        sf = f[2];
        vf = f[3];
        pf = f[4];
        case (c)
            4'b0000: cond_eval = 1'b1;
            4'b0001: cond_eval = zf;
            4'b0010: cond_eval = !zf;
            4'b0011: cond_eval = cf;
            4'b0100: cond_eval = !cf;
            4'b0101: cond_eval = sf;
            4'b0110: cond_eval = !sf;
            4'b0111: cond_eval = vf;
            4'b1000: cond_eval = !vf;
            4'b1001: cond_eval = pf;
            4'b1010: cond_eval = !pf;
            4'b1011: cond_eval = sf ^ vf;
            4'b1100: cond_eval = !(sf ^ vf);
            4'b1101: cond_eval = !cf && !zf;
            4'b1110: cond_eval = !zf && !(sf ^ vf);
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign cond_true = cond_eval(cond_q, status_flags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cond_q   <= 4'd0;
            target_q <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            pcld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            pcld_q   <= pcld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        target_d  = target_q;
        valid_d   = valid_q;
        taken_d   = taken_q;
        pcld_d    = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cond_d   = req_cond;
                    target_d = req_target;
                    // A flag load in the accept cycle means the flags are stale; wait one cycle.
                    state_d  = flags_ld ? WAIT_FLAGS : EVAL;
                end
            end
            WAIT_FLAGS: state_d = EVAL;
            EVAL: begin
                taken_d = cond_true;
                pcld_d  = cond_true;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (res_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_valid = valid_q;
    assign res_taken = taken_q;
    assign pc_load   = pcld_q;
    assign pc_target = target_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] eval_cnt_q, taken_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else if (stats_clr) begin
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else if (state_q == EVAL) begin
            eval_cnt_q <= eval_cnt_q + 1'b1;
            if (cond_true) begin
                taken_cnt_q <= taken_cnt_q + 1'b1;
            end
        end
    end

    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_flag_cond_eval.sv
// Scoreboard bench for flag_cond_eval: stimulus pushes expected responses,
// a negedge monitor pops and checks them when a response first appears.
module tb_flag_cond_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  status_flags = 5'd0;
    logic        flags_ld = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cond = 4'd0;
    logic [15:0] req_target = 16'd0;
    logic        res_valid;
    logic        res_ack = 1'b0;
    logic        res_taken;
    logic        pc_load;
    logic [15:0] pc_target;
`ifdef BRANCH_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] eval_cnt;
    logic [15:0] taken_cnt;
`endif

    flag_cond_eval #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .status_flags (status_flags),
        .flags_ld     (flags_ld),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cond     (req_cond),
        .req_target   (req_target),
        .res_valid    (res_valid),
        .res_ack      (res_ack),
        .res_taken    (res_taken),
        .pc_load      (pc_load),
        .pc_target    (pc_target)
`ifdef BRANCH_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .eval_cnt     (eval_cnt),
        .taken_cnt    (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [15:0] target;
        int          exp_edge;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer samples res_valid at the edge after the negedge where it is seen.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency_edge", edge_n + 1, e.exp_edge);
                    check("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
                    check("pc_load_first", {31'd0, pc_load}, {31'd0, e.taken});
                    check("pc_target", {16'd0, pc_target}, {16'd0, e.target});
                end
            end else if (res_valid && prev_v) begin
                check("pc_load_later", {31'd0, pc_load}, 0);
            end
            prev_v = res_valid;
        end
    end

    task automatic wait_resp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 20);
        if (!res_valid) check("resp_timeout", 0, 1);
    endtask

    task automatic issue(input logic [3:0] c, input logic [15:0] tgt, input logic [4:0] fl,
                         input logic ld, input logic [4:0] nfl, input logic exp_taken);
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 1);
        status_flags = fl;
        flags_ld     = ld;
        req_cond     = c;
        req_target   = tgt;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        e.taken    = exp_taken;
        e.target   = tgt;
        e.exp_edge = edge_n + (ld ? 3 : 2);
        sb.push_back(e);
        req_valid    = 1'b0;
        flags_ld     = 1'b0;
        status_flags = nfl;
    endtask

    task automatic do_req(input logic [3:0] c, input logic [15:0] tgt, input logic [4:0] fl,
                          input logic ld, input logic [4:0] nfl, input int hold,
                          input logic exp_taken, input bit clr_eval);
        issue(c, tgt, fl, ld, nfl, exp_taken);
`ifdef BRANCH_STATS_EN
        if (clr_eval) stats_clr = 1'b1;
`endif
        wait_resp();
`ifdef BRANCH_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int k = 0; k < hold; k++) begin
            check("hold_valid", {31'd0, res_valid}, 1);
            check("hold_taken", {31'd0, res_taken}, {31'd0, exp_taken});
            check("hold_ready", {31'd0, req_ready}, 0);
            check("hold_target", {16'd0, pc_target}, {16'd0, tgt});
            req_valid    = k[0];
            req_target   = 16'hDEAD;
            status_flags = ~status_flags;
            flags_ld     = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        flags_ld  = 1'b0;
        res_ack   = 1'b1;
        @(posedge clk);
        #1;
        res_ack = 1'b0;
        if (clr_eval) begin
            // keeps the argument meaningful in builds without counters
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_res_taken", {31'd0, res_taken}, 0);
        check("rst_pc_load", {31'd0, pc_load}, 0);
        check("rst_pc_target", {16'd0, pc_target}, 0);
        rst = 1'b0;

        // Basic Z-taken, hazard, then condition code sweep
        do_req(4'b0001, 16'h1234, 5'b00010, 1'b0, 5'b00010, 1, 1'b1, 1'b0);
        do_req(4'b0001, 16'h2222, 5'b00000, 1'b1, 5'b00010, 0, 1'b1, 1'b0);
        do_req(4'b1011, 16'h3001, 5'b00100, 1'b0, 5'b00100, 0, 1'b1, 1'b0);
        do_req(4'b1100, 16'h3002, 5'b00100, 1'b0, 5'b00100, 0, 1'b0, 1'b0);
        do_req(4'b1101, 16'h3003, 5'b00100, 1'b0, 5'b00100, 0, 1'b1, 1'b0);
        do_req(4'b1110, 16'h3004, 5'b00100, 1'b0, 5'b00100, 0, 1'b0, 1'b0);
        do_req(4'b1111, 16'h3005, 5'b11111, 1'b0, 5'b11111, 0, 1'b0, 1'b0);
        do_req(4'b0000, 16'h3006, 5'b00000, 1'b0, 5'b00000, 0, 1'b1, 1'b0);
        do_req(4'b0011, 16'h3007, 5'b00001, 1'b0, 5'b00001, 0, 1'b1, 1'b0);
        do_req(4'b0100, 16'h3008, 5'b00001, 1'b0, 5'b00001, 0, 1'b0, 1'b0);
        do_req(4'b1001, 16'h3009, 5'b10000, 1'b0, 5'b10000, 0, 1'b1, 1'b0);
        do_req(4'b1000, 16'h300A, 5'b01000, 1'b0, 5'b01000, 0, 1'b0, 1'b0);
        do_req(4'b0110, 16'h300B, 5'b00000, 1'b0, 5'b00000, 0, 1'b1, 1'b0);

        // Long hold with ignored requests and flag churn during RESP
        do_req(4'b0001, 16'h4444, 5'b00010, 1'b0, 5'b00010, 5, 1'b1, 1'b0);
        do_req(4'b0010, 16'h5555, 5'b00010, 1'b0, 5'b00010, 0, 1'b0, 1'b0);

        // Reset while holding a response
        issue(4'b0000, 16'hBEEF, 5'b00000, 1'b0, 5'b00000, 1'b1);
        wait_resp();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_res_valid", {31'd0, res_valid}, 0);
        check("midrst_res_taken", {31'd0, res_taken}, 0);
        check("midrst_pc_load", {31'd0, pc_load}, 0);
        check("midrst_pc_target", {16'd0, pc_target}, 0);
        check("midrst_req_ready", {31'd0, req_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        do_req(4'b0101, 16'h6666, 5'b00100, 1'b0, 5'b00100, 2, 1'b1, 1'b0);

`ifdef BRANCH_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("stats_clr_eval", {16'd0, eval_cnt}, 0);
        check("stats_clr_taken", {16'd0, taken_cnt}, 0);
        do_req(4'b0000, 16'h7001, 5'b00000, 1'b0, 5'b00000, 0, 1'b1, 1'b0);
        do_req(4'b1111, 16'h7002, 5'b00000, 1'b0, 5'b00000, 0, 1'b0, 1'b0);
        do_req(4'b0000, 16'h7003, 5'b00000, 1'b0, 5'b00000, 0, 1'b1, 1'b0);
        check("stats_eval_cnt", {16'd0, eval_cnt}, 3);
        check("stats_taken_cnt", {16'd0, taken_cnt}, 2);
        do_req(4'b0000, 16'h7004, 5'b00000, 1'b0, 5'b00000, 0, 1'b1, 1'b1);
        check("stats_clr_in_eval_e", {16'd0, eval_cnt}, 0);
        check("stats_clr_in_eval_t", {16'd0, taken_cnt}, 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
